// File: rtl/pll_sup_pkg.sv
// Shared types and default timing constants for the PLL lock supervisor.
package pll_sup_pkg;

   localparam int unsigned DefRstPulseCyc   = 16;
   localparam int unsigned DefLockStableCyc = 1024;
   localparam int unsigned DefLockTimeoutCyc = 50000;
   localparam int unsigned DefMaxRetries    = 7;

   typedef enum logic [2:0] {
      StResetPll,
      StWaitLock,
      StStabilize,
      StRun,
      StFail
   } pll_sup_state_e;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, synchronous active-low reset to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q, sync_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for a stable lock with timeout/retry, and gates the system reset.
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int unsigned RST_PULSE_CYC    = DefRstPulseCyc,
   parameter int unsigned LOCK_STABLE_CYC  = DefLockStableCyc,
   parameter int unsigned LOCK_TIMEOUT_CYC = DefLockTimeoutCyc,
   parameter int unsigned MAX_RETRIES      = DefMaxRetries
) (
   input  logic                               refclk,
   input  logic                               rst_n,
   input  logic                               pll_locked,
   output logic                               pll_rst,
   output logic                               sys_rst_n,
   output logic                               ready,
   output logic                               fail,
   output logic                               lock_lost,
   output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
);

   localparam int unsigned CntW   =
      $clog2(max3(RST_PULSE_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC)) + 1;
   localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);

   logic locked_s;

   sync_2ff u_sync (
      .clk   (refclk),
      .rst_n (rst_n),
      .d     (pll_locked),
      .q     (locked_s)
   );

   pll_sup_state_e    state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [RetryW-1:0] retry_q, retry_d;
   logic pll_rst_q, sys_rst_n_q, ready_q, fail_q, lock_lost_q;
   logic pll_rst_d, sys_rst_n_d, ready_d, fail_d, lock_lost_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CntW'(1);
      retry_d = retry_q;
      unique case (state_q)
         StResetPll: begin
            if (cnt_q == CntW'(RST_PULSE_CYC - 1)) begin
               state_d = StWaitLock;
               cnt_d   = '0;
            end
         end
         StWaitLock: begin
            // Lock is checked first so it wins over a coincident timeout.
            if (locked_s) begin
               state_d = StStabilize;
               cnt_d   = '0;
            end else if (cnt_q == CntW'(LOCK_TIMEOUT_CYC - 1)) begin
               cnt_d = '0;
               if (retry_q == RetryW'(MAX_RETRIES)) begin
                  state_d = StFail;
               end else begin
                  state_d = StResetPll;
                  retry_d = retry_q + RetryW'(1);
               end
            end
         end
         StStabilize: begin
            if (!locked_s) begin
               state_d = StWaitLock;
               cnt_d   = '0;
            end else if (cnt_q == CntW'(LOCK_STABLE_CYC - 1)) begin
               state_d = StRun;
               cnt_d   = '0;
               retry_d = '0;
            end
         end
         StRun: begin
            cnt_d = '0;
            if (!locked_s) begin
               state_d = StResetPll;
            end
         end
         StFail: begin
            cnt_d = '0;
         end
         default: begin
            state_d = StResetPll;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they register alongside it.
   always_comb begin
      pll_rst_d   = (state_d == StResetPll) || (state_d == StFail);
      sys_rst_n_d = (state_d == StRun);
      ready_d     = (state_d == StRun);
      fail_d      = (state_d == StFail);
      lock_lost_d = (state_q == StRun) && (state_d == StResetPll);
   end

   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         state_q     <= StResetPll;
         cnt_q       <= '0;
         retry_q     <= '0;
         pll_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
         fail_q      <= 1'b0;
         lock_lost_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         pll_rst_q   <= pll_rst_d;
         sys_rst_n_q <= sys_rst_n_d;
         ready_q     <= ready_d;
         fail_q      <= fail_d;
         lock_lost_q <= lock_lost_d;
      end
   end

   assign pll_rst   = pll_rst_q;
   assign sys_rst_n = sys_rst_n_q;
   assign ready     = ready_q;
   assign fail      = fail_q;
   assign lock_lost = lock_lost_q;
   assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short timing parameters.
module tb_pll_lock_supervisor;

   logic       refclk;
   logic       rst_n;
   logic       pll_locked;
   logic       pll_rst;
   logic       sys_rst_n;
   logic       ready;
   logic       fail;
   logic       lock_lost;
   logic [1:0] retry_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int highs;

   pll_lock_supervisor #(
      .RST_PULSE_CYC    (4),
      .LOCK_STABLE_CYC  (8),
      .LOCK_TIMEOUT_CYC (20),
      .MAX_RETRIES      (2)
   ) dut (
      .refclk     (refclk),
      .rst_n      (rst_n),
      .pll_locked (pll_locked),
      .pll_rst    (pll_rst),
      .sys_rst_n  (sys_rst_n),
      .ready      (ready),
      .fail       (fail),
      .lock_lost  (lock_lost),
      .retry_cnt  (retry_cnt)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   // Advance n rising edges, then settle 1 ns past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge refclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pll_rst"}, 32'(pll_rst), 1);
      chk({tag, "_sys_rst_n"}, 32'(sys_rst_n), 0);
      chk({tag, "_ready"}, 32'(ready), 0);
      chk({tag, "_fail"}, 32'(fail), 0);
      chk({tag, "_lock_lost"}, 32'(lock_lost), 0);
      chk({tag, "_retry"}, 32'(retry_cnt), 0);
   endtask

   initial begin
      rst_n      = 1'b0;
      pll_locked = 1'b0;

      // Normal lock; cycle numbers below count edges from the last reset edge e0.
      step(3);
      chk_reset_vals("rst");
      rst_n = 1'b1;
      step(3);
      chk("pulse_hi_e3", 32'(pll_rst), 1);
      step(1);
      chk("pulse_lo_e4", 32'(pll_rst), 0);
      chk("sysrst_e4", 32'(sys_rst_n), 0);
      step(6);
      pll_locked = 1'b1;
      step(10);
      chk("ready_early_e20", 32'(ready), 0);
      step(1);
      chk("ready_e21", 32'(ready), 1);
      chk("sysrst_e21", 32'(sys_rst_n), 1);
      chk("retry_e21", 32'(retry_cnt), 0);
      chk("pllrst_run", 32'(pll_rst), 0);

      // Loss of lock in RUN.
      step(3);
      chk("ready_e24", 32'(ready), 1);
      pll_locked = 1'b0;
      step(2);
      chk("ll_early", 32'(lock_lost), 0);
      chk("ready_hold", 32'(ready), 1);
      step(1);
      chk("ll_pulse", 32'(lock_lost), 1);
      chk("ll_sysrst", 32'(sys_rst_n), 0);
      chk("ll_ready", 32'(ready), 0);
      chk("ll_pllrst", 32'(pll_rst), 1);
      step(1);
      chk("ll_once", 32'(lock_lost), 0);
      chk("ll_pllrst2", 32'(pll_rst), 1);
      step(2);
      chk("ll_pllrst4", 32'(pll_rst), 1);
      step(1);
      chk("ll_pllrst_end", 32'(pll_rst), 0);
      pll_locked = 1'b1;
      step(10);
      chk("relock_early", 32'(ready), 0);
      step(1);
      chk("relock_ready", 32'(ready), 1);
      chk("relock_retry", 32'(retry_cnt), 0);

      // Reset mid-run, then a lock glitch during STABILIZE.
      pll_locked = 1'b0;
      rst_n      = 1'b0;
      step(1);
      chk_reset_vals("midrun");
      rst_n = 1'b1;
      step(6);
      pll_locked = 1'b1;
      step(5);
      pll_locked = 1'b0;
      step(1);
      pll_locked = 1'b1;
      step(1);
      chk("glitch_e13", 32'(ready), 0);
      step(9);
      chk("glitch_e22", 32'(ready), 0);
      step(1);
      chk("glitch_ready", 32'(ready), 1);
      chk("glitch_retry", 32'(retry_cnt), 0);

      // Lock arriving in the timeout cycle beats the timeout.
      pll_locked = 1'b0;
      rst_n      = 1'b0;
      step(1);
      rst_n = 1'b1;
      step(21);
      pll_locked = 1'b1;
      step(3);
      chk("prio_pllrst", 32'(pll_rst), 0);
      chk("prio_retry", 32'(retry_cnt), 0);
      step(8);
      chk("prio_ready", 32'(ready), 1);

      // Never lock: three pulses then FAIL.
      pll_locked = 1'b0;
      rst_n      = 1'b0;
      step(1);
      rst_n = 1'b1;
      highs = 0;
      for (int c = 1; c <= 72; c++) begin
         step(1);
         highs += int'(pll_rst);
         if (c == 23) chk("nl_retry_e23", 32'(retry_cnt), 0);
         if (c == 24) chk("nl_retry_e24", 32'(retry_cnt), 1);
         if (c == 28) chk("nl_pulse2_end", 32'(pll_rst), 0);
         if (c == 48) chk("nl_retry_e48", 32'(retry_cnt), 2);
         if (c == 71) chk("nl_fail_e71", 32'(fail), 0);
      end
      chk("nl_pllrst_highs", 32'(highs), 12);
      chk("nl_fail", 32'(fail), 1);
      chk("nl_fail_pllrst", 32'(pll_rst), 1);
      chk("nl_fail_retry", 32'(retry_cnt), 2);
      chk("nl_fail_sysrst", 32'(sys_rst_n), 0);
      pll_locked = 1'b1;
      step(20);
      chk("fail_sticky", 32'(fail), 1);
      chk("fail_pllrst", 32'(pll_rst), 1);
      chk("fail_ready", 32'(ready), 0);

      // Reset out of FAIL restarts the sequence.
      pll_locked = 1'b0;
      rst_n      = 1'b0;
      step(1);
      chk_reset_vals("fromfail");
      rst_n = 1'b1;
      step(4);
      chk("restart_pllrst", 32'(pll_rst), 0);
      chk("restart_fail", 32'(fail), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
